// File: rtl/mux_n_skid.sv
// mux_n_skid: N-input operand selector with registered output and a two-entry
// skid buffer. The select is resolved at accept time; the upstream ready is a
// registered flop derived from the next FSM state.
module mux_n_skid #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_IN   = 4,
  localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DATA_W-1:0]   in_bus,
  input  logic [SEL_W-1:0]         select,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err,
  input  logic                     err_clr
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              sel_err_q, sel_err_d;
  logic              accept;
  logic              transfer;
  logic              sel_oor;
  logic [DATA_W-1:0] resolved;

  assign accept   = in_valid & in_ready_q;
  assign transfer = (state_q != ST_EMPTY) & out_ready;

  // Select the addressed input; unmatched codes fall through to the last input.
  always_comb begin
    resolved = in_bus[(N_IN-1)*DATA_W +: DATA_W];
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (select == SEL_W'(k)) begin
        resolved = in_bus[k*DATA_W +: DATA_W];
      end
    end
  end

  // Out-of-range detection only exists when N_IN leaves unused select codes.
  if ((1 << SEL_W) == N_IN) begin : g_pow2
    assign sel_oor = 1'b0;
  end else begin : g_npow2
    assign sel_oor = (select > SEL_W'(N_IN - 1));
  end

  // Next-state and datapath steering for the main/skid pair.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = resolved;
        end
      end
      ST_ONE: begin
        if (accept && transfer) begin
          main_d = resolved;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = resolved;
        end else if (transfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (transfer) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Sticky select error: a new out-of-range accept overrides a clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (err_clr) begin
      sel_err_d = 1'b0;
    end
    if (accept && sel_oor) begin
      sel_err_d = 1'b1;
    end
  end

  // State, storage, ready and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_FULL);
      sel_err_q  <= sel_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_n_skid.sv
// tb_mux_n_skid: directed checks on three configurations of mux_n_skid plus a
// randomised valid/ready stream against a queue scoreboard.
module tb_mux_n_skid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // DUT A: DATA_W=16, N_IN=4
  logic [63:0] in_bus4;
  logic [1:0]  sel4;
  logic        iv4, ir4, ov4, or4, se4, ec4;
  logic [15:0] od4;

  // DUT B: DATA_W=16, N_IN=3
  logic [47:0] in_bus3;
  logic [1:0]  sel3;
  logic        iv3, ir3, ov3, or3, se3, ec3;
  logic [15:0] od3;

  // DUT C: DATA_W=32, N_IN=5
  logic [159:0] in_bus5;
  logic [2:0]   sel5;
  logic         iv5, ir5, ov5, or5, se5, ec5;
  logic [31:0]  od5;

  mux_n_skid #(.DATA_W(16), .N_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus4), .select(sel4),
    .in_valid(iv4), .in_ready(ir4), .out_data(od4), .out_valid(ov4),
    .out_ready(or4), .sel_err(se4), .err_clr(ec4)
  );

  mux_n_skid #(.DATA_W(16), .N_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .select(sel3),
    .in_valid(iv3), .in_ready(ir3), .out_data(od3), .out_valid(ov3),
    .out_ready(or3), .sel_err(se3), .err_clr(ec3)
  );

  mux_n_skid #(.DATA_W(32), .N_IN(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus5), .select(sel5),
    .in_valid(iv5), .in_ready(ir5), .out_data(od5), .out_valid(ov5),
    .out_ready(or5), .sel_err(se5), .err_clr(ec5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] stream_exp [4];
  logic [31:0] sb_q [$];
  logic [31:0] exp_word;
  logic        exp_se5;
  logic        acc5, xfer5;

  initial begin
    rst_n = 1'b0;
    in_bus4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    sel4 = 2'd1; iv4 = 1'b1; or4 = 1'b1; ec4 = 1'b0;
    in_bus3 = '0; sel3 = 2'd3; iv3 = 1'b1; or3 = 1'b1; ec3 = 1'b0;
    in_bus5 = '0; sel5 = '0; iv5 = 1'b0; or5 = 1'b0; ec5 = 1'b0;

    // Reset: inputs ignored, all outputs zero.
    repeat (3) tick();
    check("rst_out_data", 32'(od4), 32'h0);
    check("rst_out_valid", 32'(ov4), 32'h0);
    check("rst_in_ready", 32'(ir4), 32'h0);
    check("rst_sel_err3", 32'(se3), 32'h0);
    check("rst_in_ready3", 32'(ir3), 32'h0);
    iv4 = 1'b0; iv3 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", 32'(ir4), 32'h1);
    check("rel_out_valid", 32'(ov4), 32'h0);
    tick();
    check("idle_out_valid", 32'(ov4), 32'h0);

    // Streaming at full rate.
    in_bus4 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    stream_exp[0] = 16'hAAAA; stream_exp[1] = 16'hBBBB;
    stream_exp[2] = 16'hCCCC; stream_exp[3] = 16'hDDDD;
    or4 = 1'b1; iv4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel4 = 2'(i);
      tick();
      check($sformatf("stream_data%0d", i), 32'(od4), 32'(stream_exp[i]));
      check($sformatf("stream_valid%0d", i), 32'(ov4), 32'h1);
      check($sformatf("stream_ready%0d", i), 32'(ir4), 32'h1);
    end
    iv4 = 1'b0;
    tick();
    check("stream_drain_valid", 32'(ov4), 32'h0);

    // Stall: fill main and skid, then release.
    in_bus4 = {16'h0000, 16'h0000, 16'h2222, 16'h1111};
    or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
    tick();
    check("stall_one_data", 32'(od4), 32'h1111);
    check("stall_one_ready", 32'(ir4), 32'h1);
    sel4 = 2'd1;
    tick();
    check("stall_full_ready", 32'(ir4), 32'h0);
    check("stall_full_data", 32'(od4), 32'h1111);
    iv4 = 1'b0;
    tick();
    check("stall_hold_data", 32'(od4), 32'h1111);
    check("stall_hold_valid", 32'(ov4), 32'h1);
    check("stall_hold_ready", 32'(ir4), 32'h0);
    or4 = 1'b1;
    tick();
    check("stall_rel_data", 32'(od4), 32'h2222);
    check("stall_rel_ready", 32'(ir4), 32'h1);
    tick();
    check("stall_empty_valid", 32'(ov4), 32'h0);

    // Out-of-range select on N_IN=3.
    in_bus3 = {16'h3333, 16'h2222, 16'h1111};
    iv3 = 1'b1; sel3 = 2'd3; or3 = 1'b1;
    tick();
    check("oor_data", 32'(od3), 32'h3333);
    check("oor_err_set", 32'(se3), 32'h1);
    iv3 = 1'b0; ec3 = 1'b1;
    tick();
    check("oor_err_clr", 32'(se3), 32'h0);
    iv3 = 1'b1; sel3 = 2'd3; ec3 = 1'b1;
    tick();
    check("oor_set_wins", 32'(se3), 32'h1);
    check("oor_data2", 32'(od3), 32'h3333);
    ec3 = 1'b0; sel3 = 2'd1;
    tick();
    check("inrange_data", 32'(od3), 32'h2222);
    check("err_sticky", 32'(se3), 32'h1);
    iv3 = 1'b0;
    tick();

    // Mid-operation reset from FULL.
    in_bus4 = {16'h0000, 16'h0000, 16'h6666, 16'h5555};
    or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
    tick();
    sel4 = 2'd1;
    tick();
    check("mid_full_ready", 32'(ir4), 32'h0);
    iv4 = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(ov4), 32'h0);
    check("mid_rst_data", 32'(od4), 32'h0);
    check("mid_rst_ready", 32'(ir4), 32'h0);
    rst_n = 1'b1;
    or4 = 1'b1;
    tick();
    check("mid_rel_ready", 32'(ir4), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_no_emit%0d", i), 32'(ov4), 32'h0);
    end

    // Random valid/ready stream on N_IN=5 against a queue scoreboard.
    exp_se5 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int j = 0; j < 5; j++) begin
        in_bus5[j*32 +: 32] = $urandom;
      end
      sel5 = 3'($urandom_range(7));
      iv5  = ($urandom_range(3) != 0);
      or5  = ($urandom_range(2) != 0);
      acc5  = iv5 & ir5;
      xfer5 = ov5 & or5;
      check("rand_valid", 32'(ov5), 32'(sb_q.size() != 0));
      if (xfer5) begin
        if (sb_q.size() == 0) begin
          check("rand_underflow", 32'(od5), 32'hFFFF_FFFF);
        end else begin
          check("rand_data", od5, sb_q.pop_front());
        end
      end
      if (acc5) begin
        if (sel5 < 3'd5) begin
          exp_word = in_bus5[sel5*32 +: 32];
        end else begin
          exp_word = in_bus5[4*32 +: 32];
          exp_se5  = 1'b1;
        end
        sb_q.push_back(exp_word);
      end
      tick();
    end
    iv5 = 1'b0; or5 = 1'b1;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
      if (ov5) begin
        check("drain_data", od5, sb_q.pop_front());
      end
      tick();
    end
    check("drain_empty", 32'(sb_q.size()), 32'h0);
    check("drain_valid", 32'(ov5), 32'h0);
    check("rand_sel_err", 32'(se5), 32'(exp_se5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
